// File: rtl/prio_enc_pkg.sv
// Shared definitions for the priority-encoder cores: implementation selectors
// and the index-width helper used to size result buses.
package prio_enc_pkg;

  localparam int ENC_CASE = 0;
  localparam int ENC_IF   = 1;
  localparam int ENC_LOOP = 2;

  // A two-input encoder still needs one index bit.
  function automatic int idx_width(input int width);
    return (width <= 2) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/prio_enc_core.sv
// Combinational MSB-first priority encoder with three selectable, independently
// written implementations. Result is {valid, index}.
module prio_enc_core
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IMPL  = ENC_CASE
) (
  input  logic [WIDTH-1:0]          a,
  output logic [idx_width(WIDTH):0] y
);

  localparam int IW = idx_width(WIDTH);

  if (IMPL == ENC_CASE) begin : g_case
    if (WIDTH == 2) begin : g_w2
      always_comb begin
        casez (a)
          2'b1?:   y = 2'b11;
          2'b01:   y = 2'b10;
          default: y = 2'b00;
        endcase
      end
    end else if (WIDTH == 4) begin : g_w4
      always_comb begin
        casez (a)
          4'b1???: y = 3'b111;
          4'b01??: y = 3'b110;
          4'b001?: y = 3'b101;
          4'b0001: y = 3'b100;
          default: y = 3'b000;
        endcase
      end
    end else if (WIDTH == 8) begin : g_w8
      always_comb begin
        casez (a)
          8'b1???????: y = {1'b1, 3'd7};
          8'b01??????: y = {1'b1, 3'd6};
          8'b001?????: y = {1'b1, 3'd5};
          8'b0001????: y = {1'b1, 3'd4};
          8'b00001???: y = {1'b1, 3'd3};
          8'b000001??: y = {1'b1, 3'd2};
          8'b0000001?: y = {1'b1, 3'd1};
          8'b00000001: y = {1'b1, 3'd0};
          default:     y = '0;
        endcase
      end
    end else begin : g_w16
      always_comb begin
        casez (a)
          16'b1???????????????: y = {1'b1, 4'd15};
          16'b01??????????????: y = {1'b1, 4'd14};
          16'b001?????????????: y = {1'b1, 4'd13};
          16'b0001????????????: y = {1'b1, 4'd12};
          16'b00001???????????: y = {1'b1, 4'd11};
          16'b000001??????????: y = {1'b1, 4'd10};
          16'b0000001?????????: y = {1'b1, 4'd9};
          16'b00000001????????: y = {1'b1, 4'd8};
          16'b000000001???????: y = {1'b1, 4'd7};
          16'b0000000001??????: y = {1'b1, 4'd6};
          16'b00000000001?????: y = {1'b1, 4'd5};
          16'b000000000001????: y = {1'b1, 4'd4};
          16'b0000000000001???: y = {1'b1, 4'd3};
          16'b00000000000001??: y = {1'b1, 4'd2};
          16'b000000000000001?: y = {1'b1, 4'd1};
          16'b0000000000000001: y = {1'b1, 4'd0};
          default:              y = '0;
        endcase
      end
    end
  end else if (IMPL == ENC_IF) begin : g_if
    // Unrolled else-if chain from the MSB: the first hit blocks all lower bits.
    always_comb begin
      logic hit;
      hit = 1'b0;
      y   = '0;
      for (int i = WIDTH - 1; i >= 0; i--) begin
        if (hit) begin
          hit = 1'b1;
        end else if (a[i]) begin
          hit = 1'b1;
          y   = {1'b1, IW'(i)};
        end
      end
    end
  end else begin : g_loop
    // Scan upward; a later (higher) hit overwrites an earlier one.
    always_comb begin
      y = '0;
      for (int i = 0; i < WIDTH; i++) begin
        if (a[i]) y = {1'b1, IW'(i)};
      end
    end
  end

endmodule

// File: rtl/prio_enc4_reg.sv
// Registered priority encoder: three encoder cores run in parallel, core 0
// drives the output and any disagreement between cores is flagged.
module prio_enc4_reg
  import prio_enc_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [WIDTH-1:0]          a,
  output logic [idx_width(WIDTH):0] y,
  output logic                      mismatch
);

  localparam int IW = idx_width(WIDTH);

  logic [IW:0] enc_case;
  logic [IW:0] enc_if;
  logic [IW:0] enc_loop;
  logic        disagree;

  prio_enc_core #(.WIDTH(WIDTH), .IMPL(ENC_CASE)) u_case (.a(a), .y(enc_case));
  prio_enc_core #(.WIDTH(WIDTH), .IMPL(ENC_IF))   u_if   (.a(a), .y(enc_if));
  prio_enc_core #(.WIDTH(WIDTH), .IMPL(ENC_LOOP)) u_loop (.a(a), .y(enc_loop));

  assign disagree = (enc_case != enc_if) | (enc_case != enc_loop);

  // Output register stage
  always_ff @(posedge clk) begin
    if (rst) begin
      y        <= '0;
      mismatch <= 1'b0;
    end else begin
      y        <= enc_case;
      mismatch <= disagree;
    end
  end

endmodule

// File: tb/tb_prio_enc4_reg.sv
// Randomised scoreboard bench for prio_enc4_reg: the driver queues expected
// results, a monitor compares them against the registered outputs.
module tb_prio_enc4_reg;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a   = '0;
  logic [2:0] y;
  logic       mismatch;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [2:0] exp_y;
    bit         check;
    int         id;
  } exp_t;

  exp_t sb[$];
  int   issued = 0;

  prio_enc4_reg #(.WIDTH(4)) dut (
    .clk(clk), .rst(rst), .a(a), .y(y), .mismatch(mismatch)
  );

  always #5 clk = ~clk;

  // Reference: valid when nonzero, index = floor(log2(v)).
  function automatic logic [2:0] ref_enc(input int v);
    int idx;
    if (v == 0) return 3'b000;
    idx = 0;
    while (v > 1) begin
      v = v / 2;
      idx++;
    end
    return {1'b1, 2'(idx)};
  endfunction

  task automatic drive(input logic [3:0] val, input logic r, input bit chk);
    exp_t e;
    @(negedge clk);
    a   = val;
    rst = r;
    e.exp_y = r ? 3'b000 : ref_enc(int'(val));
    e.check = chk;
    e.id    = issued;
    issued++;
    sb.push_back(e);
  endtask

  // Monitor: one result per clock, one clock after sampling.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      if (e.check) begin
        n_tests++;
        if (y !== e.exp_y) begin
          n_fail++;
          $display("FAIL y[%0d]: got %b expected %b", e.id, y, e.exp_y);
        end
        n_tests++;
        if (mismatch !== 1'b0) begin
          n_fail++;
          $display("FAIL mismatch[%0d]: got %b expected 0", e.id, mismatch);
        end
      end
    end
  end

  initial begin
    int perm[16];
    logic [3:0] xval;

    // Reset held with all requests active
    drive(4'b1111, 1'b1, 1'b1);
    drive(4'b1111, 1'b1, 1'b1);
    drive(4'b1111, 1'b0, 1'b1);

    // Directed sweep and single-bit walk
    drive(4'b0001, 1'b0, 1'b1);
    drive(4'b1111, 1'b0, 1'b1);
    drive(4'b1010, 1'b0, 1'b1);
    drive(4'b1100, 1'b0, 1'b1);
    drive(4'b1000, 1'b0, 1'b1);
    drive(4'b0000, 1'b0, 1'b1);
    drive(4'b0001, 1'b0, 1'b1);
    drive(4'b0010, 1'b0, 1'b1);
    drive(4'b0100, 1'b0, 1'b1);
    drive(4'b1000, 1'b0, 1'b1);

    // Exhaustive in shuffled order
    for (int i = 0; i < 16; i++) perm[i] = i;
    for (int i = 15; i > 0; i--) begin
      int j;
      int t;
      j = int'($urandom_range(i, 0));
      t = perm[i]; perm[i] = perm[j]; perm[j] = t;
    end
    for (int i = 0; i < 16; i++) drive(4'(perm[i]), 1'b0, 1'b1);

    // Mid-stream reset: pending result dropped, then clean restart
    drive(4'b0110, 1'b0, 1'b1);
    drive(4'b0110, 1'b1, 1'b1);
    drive(4'b0011, 1'b0, 1'b1);
    drive(4'b1001, 1'b0, 1'b1);
    drive(4'b0110, 1'b1, 1'b1);
    drive(4'b0011, 1'b0, 1'b1);

    // Unknown input cycle is not checked; the next one must be correct
    xval = 4'bxxxx;
    drive(xval, 1'b0, 1'b0);
    drive(4'b0100, 1'b0, 1'b1);

    // Random traffic with occasional reset
    for (int i = 0; i < 200; i++) begin
      logic r;
      r = ($urandom_range(19, 0) == 0);
      drive(4'($urandom), r, 1'b1);
    end

    // Drain the scoreboard within a bounded number of cycles
    for (int k = 0; k < 10 && sb.size() > 0; k++) @(posedge clk);
    @(negedge clk);
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d results outstanding, expected 0", sb.size());
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule
